// File: rtl/adder_rr_sched.sv
// Round-robin arbiter sharing one external combinational adder among NREQ requesters.
// Accept at T, result at T+2. Holds the result until rsp_ready and accepts nothing meanwhile.
module adder_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [31:0]           ops_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   cur_id;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              op_cin;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;

  // Search starts just after the last grant so a held request is served within NREQ grants.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      cur_id     <= '0;
      last_grant <= ID_W'(NREQ - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a       <= req_a[winner*WIDTH +: WIDTH];
            op_b       <= req_b[winner*WIDTH +: WIDTH];
            op_cin     <= req_cin[winner];
            cur_id     <= winner;
            last_grant <= winner;
          end
        end
        ISSUE: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand registers only load on accept, so the adder inputs stay quiet while idle.
  assign add_a   = op_a;
  assign add_b   = op_b;
  assign add_cin = op_cin;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched with a behavioural stand-in for the shared adder.
module tb_adder_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_cin = '0;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic                  add_cin;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [31:0]           ops_done;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  adder_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .ops_done(ops_done)
  );

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req_valid = '0;
    rsp_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[r*WIDTH +: WIDTH] = a;
    req_b[r*WIDTH +: WIDTH] = b;
    req_cin[r] = cin;
  endtask

  // One isolated request from requester r, completed with a single response handshake.
  task automatic single(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic [31:0] es, input logic ec, input logic [31:0] eops);
    load(r, a, b, cin);
    req_valid = '0;
    req_valid[r] = 1'b1;
    #1;
    chk("accept_ready", 64'(req_ready), 64'(1) << r);
    tick();
    req_valid = '0;
    chk("issue_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("issue_add_a", 64'(add_a), 64'(a));
    tick();
    chk("resp_valid_t2", 64'(rsp_valid), 64'd1);
    chk("resp_sum", 64'(rsp_sum), 64'(es));
    chk("resp_cout", 64'(rsp_cout), 64'(ec));
    chk("resp_id", 64'(rsp_id), 64'(r));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("done_valid_clear", 64'(rsp_valid), 64'd0);
    chk("done_ops", 64'(ops_done), 64'(eops));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got;
    int last_cyc;
    int cycles;
    logic [31:0] held_sum;
    logic        held_cout;
    logic [1:0]  held_id;

    vecs[0] = '{r: 0, a: 32'h00000005, b: 32'h00000003, cin: 1'b1, s: 32'h00000009, c: 1'b0};
    vecs[1] = '{r: 1, a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, s: 32'h00000000, c: 1'b1};
    vecs[2] = '{r: 2, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, cin: 1'b1, s: 32'hFFFFFFFF, c: 1'b1};
    vecs[3] = '{r: 3, a: 32'h12345678, b: 32'h11111111, cin: 1'b0, s: 32'h23456789, c: 1'b0};
    vecs[4] = '{r: 0, a: 32'h80000000, b: 32'h80000000, cin: 1'b0, s: 32'h00000000, c: 1'b1};
    vecs[5] = '{r: 1, a: 32'h00000000, b: 32'h00000000, cin: 1'b1, s: 32'h00000001, c: 1'b0};

    reset_dut();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_cin", 64'(add_cin), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);

    for (int i = 0; i < 6; i++) begin
      single(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 32'(i + 1));
    end
    repeat (3) tick();
    chk("idle_add_a_hold", 64'(add_a), 64'h0);
    chk("idle_add_cin_hold", 64'(add_cin), 64'd1);

    // All four requesters held valid with the consumer always ready.
    reset_dut();
    for (int i = 0; i < NREQ; i++) load(i, 32'(i * 16), 32'd1, 1'b0);
    req_valid = '1;
    rsp_ready = 1'b1;
    got = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (rsp_valid) begin
        chk("rr_id", 64'(rsp_id), 64'(got % 4));
        chk("rr_sum", 64'(rsp_sum), 64'((got % 4) * 16 + 1));
        if (last_cyc >= 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd3);
        last_cyc = cyc;
        got++;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("rr_count", 64'(got), 64'd8);
    chk("rr_ops_done", 64'(ops_done), 64'd8);

    // Consumer stalls for 10 cycles in RESP.
    reset_dut();
    load(0, 32'h0000_1000, 32'h0000_0234, 1'b1);
    req_valid = '1;
    #1;
    chk("stall_accept", 64'(req_ready), 64'b0001);
    tick();
    tick();
    held_sum = rsp_sum;
    held_cout = rsp_cout;
    held_id = rsp_id;
    chk("stall_sum", 64'(rsp_sum), 64'h1235);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_sum_hold", 64'(rsp_sum), 64'(held_sum));
      chk("stall_cout_hold", 64'(rsp_cout), 64'(held_cout));
      chk("stall_id_hold", 64'(rsp_id), 64'(held_id));
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_ops", 64'(ops_done), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_release_valid", 64'(rsp_valid), 64'd0);
    chk("stall_release_ops", 64'(ops_done), 64'd1);
    chk("stall_next_grant", 64'(req_ready), 64'b0010);
    rsp_ready = 1'b0;
    req_valid = '0;
    repeat (4) tick();
    chk("stall_single_hs", 64'(ops_done), 64'd1);

    // Reset while in ISSUE, after one completed op and a grant to requester 2.
    reset_dut();
    single(1, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 32'd1);
    load(2, 32'd7, 32'd8, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_issue_valid", 64'(rsp_valid), 64'd0);
    chk("rst_issue_ops", 64'(ops_done), 64'd0);
    req_valid = '1;
    #1;
    chk("rst_issue_grant0", 64'(req_ready), 64'b0001);
    req_valid = '0;
    tick();
    repeat (3) tick();
    chk("rst_issue_no_rsp", 64'(rsp_valid), 64'd0);

    // Reset while in RESP with a pending result from requester 3.
    reset_dut();
    single(2, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 32'd1);
    load(3, 32'h55, 32'h11, 1'b0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    chk("pre_rst_resp_valid", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_resp_ops", 64'(ops_done), 64'd0);
    chk("rst_resp_sum", 64'(rsp_sum), 64'd0);
    req_valid = '1;
    #1;
    chk("rst_resp_grant0", 64'(req_ready), 64'b0001);
    req_valid = '0;
    tick();
    tick();
    tick();

    // Wrapped search: grant 3, then req2 alone, then req1 raised right after.
    reset_dut();
    single(3, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 32'd1);
    load(2, 32'd100, 32'd1, 1'b0);
    load(1, 32'd200, 32'd2, 1'b1);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("wrap_grant2", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b0010;
    cycles = 1;
    while (!req_ready[1] && cycles < 20) begin
      tick();
      cycles++;
    end
    chk("wrap_gap", 64'(cycles), 64'd3);
    tick();
    req_valid = '0;
    got = 0;
    for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
      if (rsp_valid) begin
        chk("wrap_id1", 64'(rsp_id), 64'd1);
        chk("wrap_sum1", 64'(rsp_sum), 64'd203);
        got = 1;
      end
      tick();
    end
    chk("wrap_rsp_seen", 64'(got), 64'd1);
    chk("wrap_ops", 64'(ops_done), 64'd3);
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
